// File: rtl/oct_pe_pkg.sv
// ============================================================================
//  Module   : oct_pe_pkg
//  Brief    : Shared PE constants: weight-read scheduler state encoding,
//             default pad address widths and pad read latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package oct_pe_pkg;

  // Default weight pad / pixel count address widths
  localparam int c_aw_pad    = 8;
  localparam int c_af_pad    = 8;
  // Pad read latency, address presented -> weight_out valid (cycles, >= 1)
  localparam int c_issue_lat = 1;

  // Scheduler state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KICK   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sched_valid_pipe.sv
// ============================================================================
//  Module   : sched_valid_pipe
//  Brief    : DEPTH-deep shift register carrying {valid, last, pixel_idx}
//             alongside the pad read, so sideband lines up with pad data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sched_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // Next stage contents: new entry at stage 0, everything else moves up one
  always_comb begin
    stage_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_data = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/weight_read_sched.sv
// ============================================================================
//  Module   : weight_read_sched
//  Brief    : Weight scratchpad read scheduler. Kicks the weight loader, then
//             streams pad read addresses once per output pixel, throttled by
//             pad fill status on the first pass only.
//  Options  : WEIGHT_SCHED_PERF_EN adds the stall_cycles counter/port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module weight_read_sched
  import oct_pe_pkg::*;
#(
  parameter int ADDRESSWIDTH_W_PAD = c_aw_pad,
  parameter int ADDRESSWIDTH_F_PAD = c_af_pad,
  parameter int ISSUE_LAT          = c_issue_lat
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
  output logic                          busy,
  output logic                          done,
  output logic                          weight_load_start,
  input  logic                          pad_data_ready,
  input  logic                          pad_full,
  output logic [ADDRESSWIDTH_W_PAD-1:0] raddra_filter,
  output logic [ADDRESSWIDTH_W_PAD-1:0] base_address,
  input  logic                          mac_ready,
  output logic                          weight_valid,
  output logic                          weight_last,
  output logic [ADDRESSWIDTH_F_PAD-1:0] pixel_idx
`ifdef WEIGHT_SCHED_PERF_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int AW     = ADDRESSWIDTH_W_PAD;
  localparam int AF     = ADDRESSWIDTH_F_PAD;
  localparam int PIPE_W = AF + 2;

  sched_state_e  state_q, state_d;
  logic [AW-1:0] wn_q, wn_d;
  logic [AF-1:0] pn_q, pn_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AF-1:0] pass_q, pass_d;
  logic          resident_q, resident_d;
  logic          done_q, done_d;
  logic          wls_q, wls_d;
  logic          busy_q, busy_d;
`ifdef WEIGHT_SCHED_PERF_EN
  logic [31:0]   stall_q, stall_d;
`endif

  logic              w_issue;
  logic              w_last_addr;
  logic              w_last_pass;
  logic [PIPE_W-1:0] w_pipe_in;
  logic [PIPE_W-1:0] w_pipe_out;
  logic              w_pipe_valid;
  logic              w_pipe_last;
  logic [AF-1:0]     w_pipe_pidx;

  assign w_last_addr = (raddr_q == wn_q - 1'b1);
  assign w_last_pass = (pass_q == pn_q - 1'b1);
  // Once the filter is resident the pad status lines are meaningless: the
  // loader's write pointer parks at wn-1 and would otherwise stall forever.
  assign w_issue = (state_q == ST_STREAM) & mac_ready &
                   (resident_q | (pad_data_ready & ~pad_full));

  assign w_pipe_in = {w_issue, w_issue & w_last_addr, w_issue ? pass_q : {AF{1'b0}}};
  assign {w_pipe_valid, w_pipe_last, w_pipe_pidx} = w_pipe_out;

  // Next-state logic for the job sequencer and its address/pass counters
  always_comb begin
    state_d    = state_q;
    wn_d       = wn_q;
    pn_d       = pn_q;
    raddr_d    = raddr_q;
    pass_d     = pass_q;
    resident_d = resident_q;
    done_d     = 1'b0;
    wls_d      = 1'b0;
`ifdef WEIGHT_SCHED_PERF_EN
    stall_d    = stall_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped
        if (start && !done_q) begin
          wn_d = weight_num;
          pn_d = pixel_num;
          if (weight_num == '0 || pixel_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_KICK;
            wls_d   = 1'b1;
          end
        end
      end
      ST_KICK: begin
        raddr_d    = '0;
        pass_d     = '0;
        resident_d = 1'b0;
        state_d    = ST_STREAM;
`ifdef WEIGHT_SCHED_PERF_EN
        stall_d    = '0;
`endif
      end
      ST_STREAM: begin
        if (w_issue) begin
          if (w_last_addr) begin
            raddr_d    = '0;
            pass_d     = pass_q + 1'b1;
            resident_d = 1'b1;
            if (w_last_pass) begin
              state_d = ST_DRAIN;
            end
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
`ifdef WEIGHT_SCHED_PERF_EN
        else if (mac_ready && stall_q != 32'hFFFF_FFFF) begin
          stall_d = stall_q + 32'd1;
        end
`endif
      end
      ST_DRAIN: begin
        // The final weight of the final pass is unique in the pipe
        if (w_pipe_valid && w_pipe_last && w_pipe_pidx == pn_q - 1'b1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer registers; reset aborts a job without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wn_q       <= '0;
      pn_q       <= '0;
      raddr_q    <= '0;
      pass_q     <= '0;
      resident_q <= 1'b0;
      done_q     <= 1'b0;
      wls_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef WEIGHT_SCHED_PERF_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wn_q       <= wn_d;
      pn_q       <= pn_d;
      raddr_q    <= raddr_d;
      pass_q     <= pass_d;
      resident_q <= resident_d;
      done_q     <= done_d;
      wls_q      <= wls_d;
      busy_q     <= busy_d;
`ifdef WEIGHT_SCHED_PERF_EN
      stall_q    <= stall_d;
`endif
    end
  end

  sched_valid_pipe #(
    .DEPTH (ISSUE_LAT),
    .WIDTH (PIPE_W)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_data  (w_pipe_in),
    .out_data (w_pipe_out)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign weight_load_start = wls_q;
  assign raddra_filter     = raddr_q;
  assign base_address      = raddr_q;
  assign weight_valid      = w_pipe_valid;
  assign weight_last       = w_pipe_last;
  assign pixel_idx         = w_pipe_pidx;
`ifdef WEIGHT_SCHED_PERF_EN
  assign stall_cycles      = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_read_sched.sv
// ============================================================================
//  Module   : tb_weight_read_sched
//  Brief    : Self-checking bench for weight_read_sched with a transaction-
//             level reference model (weight k of a job = addr k%wn, pass k/wn).
//  Options  : WEIGHT_SCHED_PERF_EN also checks stall_cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_weight_read_sched;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] weight_num = '0;
  logic [7:0] pixel_num = '0;
  logic       busy, done, weight_load_start;
  logic       pad_data_ready = 1'b0;
  logic       pad_full = 1'b0;
  logic [7:0] raddra_filter, base_address;
  logic       mac_ready = 1'b0;
  logic       weight_valid, weight_last;
  logic [7:0] pixel_idx;
`ifdef WEIGHT_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_read_sched #(
    .ADDRESSWIDTH_W_PAD (8),
    .ADDRESSWIDTH_F_PAD (8),
    .ISSUE_LAT          (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .weight_num        (weight_num),
    .pixel_num         (pixel_num),
    .busy              (busy),
    .done              (done),
    .weight_load_start (weight_load_start),
    .pad_data_ready    (pad_data_ready),
    .pad_full          (pad_full),
    .raddra_filter     (raddra_filter),
    .base_address      (base_address),
    .mac_ready         (mac_ready),
    .weight_valid      (weight_valid),
    .weight_last       (weight_last),
    .pixel_idx         (pixel_idx)
`ifdef WEIGHT_SCHED_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  // Runs one non-empty job. Entry/exit: #1 after a posedge, DUT idle.
  // p_mac < 0 toggles mac_ready every cycle. [fs, fs+fl) forces a pad stall
  // with mac_ready high. full_p1 holds the pad "not ready" once resident.
  task automatic run_job(input string nm, input int wn, input int pn, input int p_mac,
                         input int p_ok, input int fs, input int fl,
                         input bit full_p1, input bit noisy);
    int total, k, cyc, last_issue, stall, limit, ep;
    bit m, r, f, iss, ev, el, eb, ed;
    int due_q[$];
    bit lastq[$];
    int pidxq[$];
    total = wn * pn; k = 0; last_issue = -1; stall = 0;
    limit = 20 * total + 50;
    start = 1'b1; weight_num = 8'(wn); pixel_num = 8'(pn);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < limit) begin
      n_cmp++;
      if (weight_load_start !== (cyc == 1)) begin
        n_err++;
        $display("FAIL %s wls cyc%0d: got %b want %b", nm, cyc, weight_load_start, cyc == 1);
      end
      eb = (last_issue < 0) || (cyc <= last_issue + LAT);
      n_cmp++;
      if (busy !== eb) begin
        n_err++;
        $display("FAIL %s busy cyc%0d: got %b want %b", nm, cyc, busy, eb);
      end
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front()); void'(lastq.pop_front()); void'(pidxq.pop_front());
      end
      ev = (due_q.size() > 0 && due_q[0] == cyc);
      n_cmp++;
      if (weight_valid !== ev) begin
        n_err++;
        $display("FAIL %s valid cyc%0d: got %b want %b", nm, cyc, weight_valid, ev);
      end
      if (ev) begin
        void'(due_q.pop_front());
        el = lastq.pop_front();
        ep = pidxq.pop_front();
        n_cmp++;
        if (weight_last !== el || pixel_idx !== 8'(ep)) begin
          n_err++;
          $display("FAIL %s last/pidx cyc%0d: got %b/%0d want %b/%0d",
                   nm, cyc, weight_last, pixel_idx, el, ep);
        end
      end
      ed = (last_issue >= 0) && (cyc == last_issue + LAT + 1);
      n_cmp++;
      if (done !== ed) begin
        n_err++;
        $display("FAIL %s done cyc%0d: got %b want %b", nm, cyc, done, ed);
      end
      if (ed) break;
      if (cyc >= 2 && k < total) begin
        n_cmp++;
        if (raddra_filter !== 8'(k % wn) || base_address !== 8'(k % wn)) begin
          n_err++;
          $display("FAIL %s raddr cyc%0d: got %0d/%0d want %0d",
                   nm, cyc, raddra_filter, base_address, k % wn);
        end
      end
      // Next-cycle stimulus
      if (cyc >= fs && cyc < fs + fl) begin
        m = 1'b1; r = 1'b1; f = 1'b1;
      end else begin
        m = (p_mac < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < p_mac);
        r = ($urandom_range(99) < p_ok);
        f = ($urandom_range(99) >= p_ok);
        if (full_p1 && k >= wn) begin r = 1'b0; f = 1'b1; end
      end
      mac_ready = m; pad_data_ready = r; pad_full = f;
      if (noisy) begin
        start = 1'($urandom_range(1));
        weight_num = 8'($urandom_range(255));
        pixel_num = 8'($urandom_range(255));
      end
      if (cyc >= 2 && k < total) begin
        iss = m && (k >= wn || (r && !f));
        if (iss) begin
          due_q.push_back(cyc + LAT);
          lastq.push_back((k % wn) == wn - 1);
          pidxq.push_back(k / wn);
          k++;
          if (k == total) last_issue = cyc;
        end else if (m) begin
          stall++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= limit) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: got no done in %0d cycles, want done", nm, limit);
    end
    n_cmp++;
    if (raddra_filter !== 8'd0) begin
      n_err++;
      $display("FAIL %s raddr end: got %0d want 0", nm, raddra_filter);
    end
`ifdef WEIGHT_SCHED_PERF_EN
    n_cmp++;
    if (stall_cycles !== 32'(stall)) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, stall);
    end
`endif
    // A start in the done cycle must be ignored
    start = noisy; weight_num = 8'd5; pixel_num = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (weight_load_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s post-done: got wls/busy/done %b%b%b want 000",
               nm, weight_load_start, busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, weight_load_start, raddra_filter, base_address, weight_valid,
         weight_last, pixel_idx} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got nonzero (raddr %0d pidx %0d) want all 0",
               raddra_filter, pixel_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass();
    run_job("single_pass", 4, 1, 100, 100, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reuse();
    run_job("reuse", 3, 3, 100, 100, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_pad_stall();
    run_job("pad_stall", 8, 2, 100, 100, 5, 5, 1'b1, 1'b0);
  endtask

  task automatic test_zero_job();
    for (int t = 0; t < 2; t++) begin
      start = 1'b1;
      weight_num = (t == 0) ? 8'd0 : 8'd3;
      pixel_num  = (t == 0) ? 8'd5 : 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || weight_load_start !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL zero_job%0d: got done/wls/busy %b%b%b want 100",
                 t, done, weight_load_start, busy);
      end
      repeat (3) begin
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || weight_load_start !== 1'b0 || weight_valid !== 1'b0) begin
          n_err++;
          $display("FAIL zero_job%0d idle: got done/wls/valid %b%b%b want 000",
                   t, done, weight_load_start, weight_valid);
        end
      end
    end
  endtask

  task automatic test_mac_toggle();
    run_job("mac_toggle", 4, 2, -1, 100, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_boundary();
    run_job("wn_max", 255, 2, 100, 100, 0, 0, 1'b1, 1'b0);
    run_job("pn_max", 1, 255, 80, 80, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job($sformatf("random%0d", j), int'($urandom_range(10, 1)),
              int'($urandom_range(4, 1)), int'($urandom_range(100, 40)),
              int'($urandom_range(100, 30)), 0, 0, 1'($urandom_range(1)), 1'b1);
    end
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; weight_num = 8'd5; pixel_num = 8'd3;
    mac_ready = 1'b1; pad_data_ready = 1'b1; pad_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    // Weight 7 = pass 1, addr 2 on the pad; weight 6 (pass 1) now valid
    n_cmp++;
    if (raddra_filter !== 8'd2 || weight_valid !== 1'b1 || pixel_idx !== 8'd1) begin
      n_err++;
      $display("FAIL rst_mid pre: got raddr %0d valid %b pidx %0d want 2 1 1",
               raddra_filter, weight_valid, pixel_idx);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, weight_load_start, raddra_filter, base_address, weight_valid,
         weight_last, pixel_idx} !== '0) begin
      n_err++;
      $display("FAIL rst_mid outputs: got raddr %0d valid %b pidx %0d want all 0",
               raddra_filter, weight_valid, pixel_idx);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || weight_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid after: got done/valid/busy %b%b%b want 000",
                 done, weight_valid, busy);
      end
    end
    run_job("after_rst", 5, 3, 90, 90, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_reuse();
    test_pad_stall();
    test_zero_job();
    test_mac_toggle();
    test_boundary();
    test_random();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
